// File: rtl/bch_chien_seq.sv
// Sequential Chien search for the BCH(15,7) t=2 decoder over GF(16), poly x^4+x+1.
// Evaluates lambda(x)=1+l1*x+l2*x^2 at alpha^-j, P positions per cycle, and reports
// the root positions, the root count and whether the count matches deg(lambda).
//
// state  | meaning
// IDLE   | ready for a new locator, last result still visible
// SEARCH | stepping t1/t2 through the positions, P per cycle
// DONE   | result valid, waiting for out_ready
module bch_chien_seq #(
  parameter int N = 15,
  parameter int P = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   lambda1,
  input  logic [3:0]   lambda2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] error_vector,
  output logic [1:0]   n_err,
  output logic         error_found,
  output logic         uncorrectable,
  output logic         busy
);

  localparam int STEPS = N / P;
  localparam logic [3:0] LAST = 4'(STEPS - 1);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  function automatic logic [3:0] gf_xtime(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic [3:0] s;
    r = 4'h0;
    s = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) r = r ^ s;
      s = gf_xtime(s);
    end
    return r;
  endfunction

  function automatic logic [3:0] gf_alpha(input int e);
    logic [3:0] r;
    r = 4'h1;
    for (int i = 0; i < 15; i++) begin
      if (i < e) r = gf_xtime(r);
    end
    return r;
  endfunction

  // Per-cycle advance of the running terms: alpha^-P and alpha^-2P.
  localparam logic [3:0] STEP1 = gf_alpha((15 - (P % 15)) % 15);
  localparam logic [3:0] STEP2 = gf_alpha((30 - 2 * (P % 15)) % 15);

  state_t      state;
  logic [3:0]  t1, t2;
  logic [3:0]  cnt;
  logic [1:0]  deg;
  logic [1:0]  deg_in;
  logic [N-1:0] hits;
  logic [3:0]  hit_cnt;
  logic [3:0]  n_sum;
  logic [1:0]  n_next;
  logic [N-1:0] ev_next;
  logic [3:0]  lane;

  assign in_ready  = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign deg_in    = (lambda2 != 4'h0) ? 2'd2 : ((lambda1 != 4'h0) ? 2'd1 : 2'd0);

  // Evaluate the current group of P positions and merge it into the running result.
  always_comb begin
    hits    = '0;
    hit_cnt = 4'd0;
    lane    = 4'h0;
    for (int k = 0; k < P; k++) begin
      lane = 4'h1 ^ gf_mul(t1, gf_alpha((15 - k) % 15))
                  ^ gf_mul(t2, gf_alpha((30 - 2 * k) % 15));
      if (lane == 4'h0) begin
        hits[k] = 1'b1;
        hit_cnt = hit_cnt + 4'd1;
      end
    end
    ev_next = error_vector | (hits << (cnt * P));
    n_sum   = {2'b00, n_err} + hit_cnt;
    n_next  = (n_sum > 4'd2) ? 2'd2 : n_sum[1:0];
  end

  // Control FSM and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      t1            <= 4'h0;
      t2            <= 4'h0;
      cnt           <= 4'd0;
      deg           <= 2'd0;
      error_vector  <= '0;
      n_err         <= 2'd0;
      error_found   <= 1'b0;
      uncorrectable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            t1            <= lambda1;
            t2            <= lambda2;
            deg           <= deg_in;
            cnt           <= 4'd0;
            error_vector  <= '0;
            n_err         <= 2'd0;
            error_found   <= 1'b0;
            uncorrectable <= 1'b0;
            state         <= SEARCH;
          end
        end
        SEARCH: begin
          error_vector <= ev_next;
          n_err        <= n_next;
          t1           <= gf_mul(t1, STEP1);
          t2           <= gf_mul(t2, STEP2);
          cnt          <= cnt + 4'd1;
          if (cnt == LAST) begin
            error_found   <= (n_next != 2'd0);
            uncorrectable <= (n_next != deg);
            state         <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_chien_seq.sv
// Bench for bch_chien_seq: directed locators, hold/ignore, mid-search reset,
// random and exhaustive locators for P=1, plus exhaustive runs on P=3,5,15 instances.
module tb_bch_chien_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  lambda1, lambda2;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] error_vector;
  logic [1:0]  n_err;
  logic        error_found, uncorrectable, busy;

  int total = 0;
  int bad = 0;

  logic [14:0] x_ev;
  int          x_n;
  int          x_ef, x_unc;

  always #5 clk = ~clk;

  bch_chien_seq #(.N(15), .P(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .lambda1(lambda1), .lambda2(lambda2), .out_valid(out_valid), .out_ready(out_ready),
    .error_vector(error_vector), .n_err(n_err), .error_found(error_found),
    .uncorrectable(uncorrectable), .busy(busy)
  );

  // Extra instances for the wider lane counts, out_ready tied high.
  logic        iv_x[3];
  logic        ir_x[3];
  logic        ov_x[3];
  logic [3:0]  a_x[3], b_x[3];
  logic [14:0] ev_x[3];
  logic [1:0]  ne_x[3];
  logic        ef_x[3], unc_x[3], bs_x[3];

  for (genvar g = 0; g < 3; g++) begin : g_ex
    bch_chien_seq #(.N(15), .P((g == 0) ? 3 : ((g == 1) ? 5 : 15))) u (
      .clk(clk), .rst(rst), .in_valid(iv_x[g]), .in_ready(ir_x[g]),
      .lambda1(a_x[g]), .lambda2(b_x[g]), .out_valid(ov_x[g]), .out_ready(1'b1),
      .error_vector(ev_x[g]), .n_err(ne_x[g]), .error_found(ef_x[g]),
      .uncorrectable(unc_x[g]), .busy(bs_x[g])
    );
  end

  // Reference GF(16) arithmetic through exponent/log lookups.
  function automatic int gf_exp(input int e);
    int x;
    x = 1;
    for (int i = 0; i < e; i++) begin
      x = x << 1;
      if (x >= 16) x = x ^ 19;
    end
    return x;
  endfunction

  function automatic int gf_log(input int a);
    for (int e = 0; e < 15; e++) if (gf_exp(e) == a) return e;
    return 0;
  endfunction

  function automatic int gf_m(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gf_exp((gf_log(a) + gf_log(b)) % 15);
  endfunction

  function automatic logic [14:0] model_ev(input int l1, input int l2);
    logic [14:0] v;
    int x;
    v = '0;
    for (int i = 0; i < 15; i++) begin
      x = gf_exp((15 - i) % 15);
      if ((1 ^ gf_m(l1, x) ^ gf_m(l2, gf_m(x, x))) == 0) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic int model_deg(input int l1, input int l2);
    return (l2 != 0) ? 2 : ((l1 != 0) ? 1 : 0);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic set_exp(input int a, input int b);
    x_ev  = model_ev(a, b);
    x_n   = $countones(x_ev);
    x_ef  = (x_n != 0) ? 1 : 0;
    x_unc = (x_n != model_deg(a, b)) ? 1 : 0;
  endtask

  task automatic do_accept(input logic [3:0] a, input logic [3:0] b);
    int c;
    c = 0;
    while (!in_ready && c < 50) begin
      @(posedge clk); #1; c++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    set_exp(int'(a), int'(b));
    in_valid = 1'b1;
    lambda1  = a;
    lambda2  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lambda1  = 4'($urandom);
    lambda2  = 4'($urandom);
    chk("busy_after_accept", int'(busy), 1);
    chk("ev_cleared", int'(error_vector), 0);
    chk("nerr_cleared", int'(n_err), 0);
  endtask

  task automatic finish_result(input int hold);
    int c;
    c = 0;
    while (!out_valid && c < 40) begin
      @(posedge clk); #1; c++;
    end
    chk("latency", c, 15);
    repeat (hold) begin
      in_valid = 1'($urandom);
      lambda1  = 4'($urandom);
      lambda2  = 4'($urandom);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ready_after_release", int'(in_ready), 1);
    chk("busy_after_release", int'(busy), 0);
    chk("held_ev_idle", int'(error_vector), int'(x_ev));
  endtask

  task automatic run_ex(input int g);
    int c;
    int pp;
    logic [14:0] ev;
    pp = (g == 0) ? 3 : ((g == 1) ? 5 : 15);
    for (int p = 0; p < 256; p++) begin
      c = 0;
      while (!ir_x[g] && c < 50) begin
        @(posedge clk); #1; c++;
      end
      if (!ir_x[g]) chk($sformatf("ex%0d_ready_timeout", pp), 0, 1);
      iv_x[g] = 1'b1;
      a_x[g]  = 4'(p);
      b_x[g]  = 4'(p >> 4);
      @(posedge clk); #1;
      iv_x[g] = 1'b0;
      c = 0;
      while (!ov_x[g] && c < 40) begin
        @(posedge clk); #1; c++;
      end
      ev = model_ev(p & 15, p >> 4);
      chk($sformatf("p%0d_latency", pp), c, 15 / pp);
      chk($sformatf("p%0d_ev_%0d", pp, p), int'(ev_x[g]), int'(ev));
      chk($sformatf("p%0d_nerr_%0d", pp, p), int'(ne_x[g]), $countones(ev));
      chk($sformatf("p%0d_found_%0d", pp, p), int'(ef_x[g]), (ev != 0) ? 1 : 0);
      chk($sformatf("p%0d_unc_%0d", pp, p), int'(unc_x[g]),
          ($countones(ev) != model_deg(p & 15, p >> 4)) ? 1 : 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; lambda1 = 4'h0; lambda2 = 4'h0; out_ready = 1'b0;
    for (int g = 0; g < 3; g++) begin
      iv_x[g] = 1'b0; a_x[g] = 4'h0; b_x[g] = 4'h0;
    end
    x_ev = '0; x_n = 0; x_ef = 0; x_unc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ev", int'(error_vector), 0);
    chk("rst_nerr", int'(n_err), 0);
    chk("rst_found", int'(error_found), 0);
    chk("rst_unc", int'(uncorrectable), 0);

    // Result checker: every cycle the P=1 instance presents a result.
    fork
      forever begin
        @(negedge clk);
        if (!rst && out_valid) begin
          chk("cmp_ev", int'(error_vector), int'(x_ev));
          chk("cmp_nerr", int'(n_err), x_n);
          chk("cmp_found", int'(error_found), x_ef);
          chk("cmp_unc", int'(uncorrectable), x_unc);
          chk("cmp_in_ready_done", int'(in_ready), 0);
        end
      end
    join_none

    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", int'(in_ready), 1);

    chk("pin_model_2_11", int'(model_ev(2, 11)), 'h0024);
    chk("pin_model_10_0", int'(model_ev(10, 0)), 'h0200);
    chk("pin_model_0_12", int'(model_ev(0, 12)), 'h0008);
    chk("pin_model_0_0", int'(model_ev(0, 0)), 'h0000);

    do_accept(4'd2, 4'd11); finish_result(0);
    chk("t1_ev", int'(error_vector), 'h0024);
    chk("t1_nerr", int'(n_err), 2);
    chk("t1_found", int'(error_found), 1);
    chk("t1_unc", int'(uncorrectable), 0);

    do_accept(4'd10, 4'd0); finish_result(2);
    chk("t2_ev", int'(error_vector), 'h0200);
    chk("t2_nerr", int'(n_err), 1);
    chk("t2_unc", int'(uncorrectable), 0);

    do_accept(4'd0, 4'd0); finish_result(0);
    chk("t2z_ev", int'(error_vector), 0);
    chk("t2z_nerr", int'(n_err), 0);
    chk("t2z_found", int'(error_found), 0);
    chk("t2z_unc", int'(uncorrectable), 0);

    do_accept(4'd0, 4'd12); finish_result(1);
    chk("t3_ev", int'(error_vector), 'h0008);
    chk("t3_nerr", int'(n_err), 1);
    chk("t3_unc", int'(uncorrectable), 1);

    // Long hold in DONE with junk in_valid pulses, then a normal locator.
    do_accept(4'd6, 4'd9); finish_result(7);
    do_accept(4'd2, 4'd11); finish_result(0);

    // Reset in the middle of a search.
    do_accept(4'd2, 4'd11);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ev", int'(error_vector), 0);
    chk("mid_rst_nerr", int'(n_err), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_found", int'(error_found), 0);
    @(negedge clk);
    rst = 1'b0;
    do_accept(4'd10, 4'd0); finish_result(0);
    chk("post_rst_ev", int'(error_vector), 'h0200);

    for (int r = 0; r < 30; r++) begin
      do_accept(4'($urandom), 4'($urandom));
      finish_result(int'($urandom_range(0, 3)));
    end

    for (int p = 0; p < 256; p++) begin
      do_accept(4'(p), 4'(p >> 4));
      finish_result(0);
    end

    fork
      run_ex(0);
      run_ex(1);
      run_ex(2);
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
